// File: rtl/ariane_pkg.sv
// Shared core types: scoreboard entries, exceptions and the transaction-ID width, all derived
// from the single scoreboard depth constant.
package ariane_pkg;

   localparam int unsigned NR_SB_ENTRIES = 8;
   localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

   typedef enum logic [2:0] {
      FuNone,
      FuLoad,
      FuStore,
      FuAlu,
      FuCtrlFlow,
      FuMult,
      FuCsr
   } fu_t;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [63:0]              pc;
      logic [TRANS_ID_BITS-1:0] trans_id;
      fu_t                      fu;
      logic [7:0]               op;
      logic [4:0]               rs1;
      logic [4:0]               rs2;
      logic [4:0]               rd;
      logic [63:0]              result;
      logic                     valid;
      logic                     use_imm;
      exception_t               ex;
   } scoreboard_entry_t;

endpackage

// File: rtl/commit_queue.sv
// In-order retire queue: circular buffer indexed by transaction ID, merging writebacks and
// presenting the oldest entries to commit. All outputs depend on registered state only.
module commit_queue
   import ariane_pkg::*;
#(
   parameter int unsigned NR_ENTRIES      = NR_SB_ENTRIES,
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned NR_WB_PORTS     = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  scoreboard_entry_t        issue_instr_i,
   input  logic                     issue_valid_i,
   output logic                     issue_ready_o,
   output logic [TRANS_ID_BITS-1:0] issue_trans_id_o,
   input  logic [NR_WB_PORTS-1:0]   wb_valid_i,
   input  logic [TRANS_ID_BITS-1:0] wb_trans_id_i [NR_WB_PORTS],
   input  logic [63:0]              wb_result_i [NR_WB_PORTS],
   input  exception_t               wb_ex_i [NR_WB_PORTS],
   output scoreboard_entry_t        commit_instr_o [NR_COMMIT_PORTS],
   input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
   output logic                     empty_o
);

   localparam int unsigned CntW = TRANS_ID_BITS + 1;
   localparam int unsigned RetW = $clog2(NR_COMMIT_PORTS + 1);
   localparam logic [CntW-1:0] CntFull = CntW'(NR_ENTRIES);

   scoreboard_entry_t mem_q [NR_ENTRIES];
   scoreboard_entry_t mem_d [NR_ENTRIES];
   logic [NR_ENTRIES-1:0]    busy_q, busy_d;
   logic [NR_ENTRIES-1:0]    done_q, done_d;
   logic [TRANS_ID_BITS-1:0] head_q, head_d;
   logic [TRANS_ID_BITS-1:0] tail_q, tail_d;
   logic [CntW-1:0]          cnt_q, cnt_d;

   logic                       issue_fire;
   logic [RetW-1:0]            retire_cnt;
   logic [NR_COMMIT_PORTS-1:0] commit_valid;
   logic [TRANS_ID_BITS-1:0]   commit_idx [NR_COMMIT_PORTS];

   // Ready looks only at the registered count, so a same-cycle ack cannot open a full queue.
   assign issue_ready_o    = (cnt_q != CntFull);
   assign issue_trans_id_o = tail_q;
   assign empty_o          = (cnt_q == '0);
   assign issue_fire       = issue_valid_i && issue_ready_o && !flush_i;

   always_comb begin : commit_view
      logic prev_valid;
      prev_valid = 1'b1;
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         commit_idx[i]           = head_q + TRANS_ID_BITS'(i);
         commit_valid[i]         = prev_valid && busy_q[commit_idx[i]] && done_q[commit_idx[i]];
         prev_valid              = commit_valid[i];
         commit_instr_o[i]       = mem_q[commit_idx[i]];
         commit_instr_o[i].valid = commit_valid[i];
      end
   end

   // Leading ones of the ack vector, counting only ports that are actually presenting.
   always_comb begin : retire_count
      logic run;
      run        = 1'b1;
      retire_cnt = '0;
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         run = run && commit_ack_i[i] && commit_valid[i];
         if (run) begin
            retire_cnt = retire_cnt + RetW'(1);
         end
      end
   end

   always_comb begin : next_state
      mem_d  = mem_q;
      busy_d = busy_q;
      done_d = done_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;

      // Ascending port order: on a duplicate ID the highest port wins.
      for (int k = 0; k < NR_WB_PORTS; k++) begin
         if (wb_valid_i[k] && busy_q[wb_trans_id_i[k]]) begin
            mem_d[wb_trans_id_i[k]].result = wb_result_i[k];
            done_d[wb_trans_id_i[k]]       = 1'b1;
            if (wb_ex_i[k].valid) begin
               mem_d[wb_trans_id_i[k]].ex = wb_ex_i[k];
            end
         end
      end

      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
         if (RetW'(i) < retire_cnt) begin
            busy_d[commit_idx[i]] = 1'b0;
            done_d[commit_idx[i]] = 1'b0;
         end
      end

      if (issue_fire) begin
         mem_d[tail_q]          = issue_instr_i;
         mem_d[tail_q].trans_id = tail_q;
         mem_d[tail_q].valid    = 1'b0;
         mem_d[tail_q].ex.valid = 1'b0;
         busy_d[tail_q]         = 1'b1;
         done_d[tail_q]         = 1'b0;
         tail_d                 = tail_q + TRANS_ID_BITS'(1);
      end

      head_d = head_q + TRANS_ID_BITS'(retire_cnt);
      cnt_d  = cnt_q + CntW'(issue_fire) - CntW'(retire_cnt);

      if (flush_i) begin
         busy_d = '0;
         done_d = '0;
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NR_ENTRIES; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
         done_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
         done_q <= done_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

`ifndef SYNTHESIS
   for (genvar k = 0; k < NR_WB_PORTS; k++) begin : g_wb_chk
      for (genvar l = k + 1; l < NR_WB_PORTS; l++) begin : g_pair
         a_wb_unique_id : assert property (@(posedge clk_i) disable iff (rst_i)
            !(wb_valid_i[k] && wb_valid_i[l] && (wb_trans_id_i[k] == wb_trans_id_i[l])));
      end
   end

   for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : g_ack_chk
      a_ack_on_valid : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
         commit_ack_i[i] |-> commit_valid[i]);
   end
`endif

endmodule

// File: tb/tb_commit_queue.sv
// Directed bench for commit_queue: a per-cycle vector table plus hand-written sequences for
// exception merge, asynchronous reset and pointer wrap-around.
module tb_commit_queue;
   import ariane_pkg::*;

   logic                     clk_i;
   logic                     rst_i;
   logic                     flush_i;
   scoreboard_entry_t        issue_instr_i;
   logic                     issue_valid_i;
   logic                     issue_ready_o;
   logic [TRANS_ID_BITS-1:0] issue_trans_id_o;
   logic [3:0]               wb_valid_i;
   logic [TRANS_ID_BITS-1:0] wb_trans_id_i [4];
   logic [63:0]              wb_result_i [4];
   exception_t               wb_ex_i [4];
   scoreboard_entry_t        commit_instr_o [2];
   logic [1:0]               commit_ack_i;
   logic                     empty_o;

   int n_checks = 0;
   int n_fail   = 0;
   int n_issued = 0;

   commit_queue #(
      .NR_ENTRIES      (8),
      .NR_COMMIT_PORTS (2),
      .NR_WB_PORTS     (4)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .flush_i          (flush_i),
      .issue_instr_i    (issue_instr_i),
      .issue_valid_i    (issue_valid_i),
      .issue_ready_o    (issue_ready_o),
      .issue_trans_id_o (issue_trans_id_o),
      .wb_valid_i       (wb_valid_i),
      .wb_trans_id_i    (wb_trans_id_i),
      .wb_result_i      (wb_result_i),
      .wb_ex_i          (wb_ex_i),
      .commit_instr_o   (commit_instr_o),
      .commit_ack_i     (commit_ack_i),
      .empty_o          (empty_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      int fl;   int iss;  int wbv;  int id0;  int id1;  int ack;
      int rdy;  int tid;  int emp;  int cv;   int c0;   int c1;
   } vec_t;

   vec_t vecs [$];

   function automatic vec_t v(int fl, int iss, int wbv, int id0, int id1, int ack,
                              int rdy, int tid, int emp, int cv, int c0, int c1);
      vec_t r;
      r = '{fl, iss, wbv, id0, id1, ack, rdy, tid, emp, cv, c0, c1};
      return r;
   endfunction

   // Issued instructions carry a bogus trans_id and a set ex.valid, both of which the queue
   // must overwrite.
   function automatic scoreboard_entry_t mk_instr(int n);
      scoreboard_entry_t e;
      e          = '0;
      e.pc       = 64'h8000_0000 + 64'(n * 4);
      e.trans_id = 3'h5;
      e.fu       = FuAlu;
      e.op       = 8'(n);
      e.rd       = 5'(n);
      e.ex.valid = 1'b1;
      e.ex.cause = 64'hdead;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic clear_inputs();
      flush_i       = 1'b0;
      issue_valid_i = 1'b0;
      wb_valid_i    = '0;
      commit_ack_i  = '0;
      for (int k = 0; k < 4; k++) begin
         wb_trans_id_i[k] = '0;
         wb_result_i[k]   = '0;
         wb_ex_i[k]       = '0;
      end
   endtask

   task automatic do_issue(input int exp_tid);
      chk($sformatf("issue tid #%0d", n_issued), 64'(issue_trans_id_o), 64'(exp_tid));
      issue_instr_i = mk_instr(n_issued);
      n_issued++;
      issue_valid_i = 1'b1;
      step();
      issue_valid_i = 1'b0;
   endtask

   task automatic do_wb(input int id0, input int id1);
      wb_valid_i       = 4'b0011;
      wb_trans_id_i[0] = 3'(id0);
      wb_trans_id_i[1] = 3'(id1);
      wb_result_i[0]   = 64'hA000 + 64'(id0);
      wb_result_i[1]   = 64'hA000 + 64'(id1);
      step();
      wb_valid_i = '0;
   endtask

   task automatic do_ack(input logic [1:0] a);
      commit_ack_i = a;
      step();
      commit_ack_i = '0;
   endtask

   function automatic logic [1:0] cv_now();
      return {commit_instr_o[1].valid, commit_instr_o[0].valid};
   endfunction

   initial begin
      rst_i         = 1'b1;
      issue_instr_i = '0;
      clear_inputs();
      @(negedge clk_i);
      @(negedge clk_i);
      chk("reset ready", 64'(issue_ready_o), 64'd1);
      chk("reset tid", 64'(issue_trans_id_o), 64'd0);
      chk("reset empty", 64'(empty_o), 64'd1);
      chk("reset cv", 64'(cv_now()), 64'd0);
      rst_i = 1'b0;

      //            fl iss wbv id0 id1 ack  rdy tid emp cv c0 c1
      for (int k = 1; k <= 8; k++) vecs.push_back(v(0, 1, 0, 0, 0, 0, (k < 8) ? 1 : 0, k % 8, 0, 0, 0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));  // issue while full
      vecs.push_back(v(0, 0, 3, 0, 1, 0,  0, 0, 0, 3, 0, 1));
      vecs.push_back(v(0, 1, 0, 0, 0, 3,  1, 0, 0, 0, 0, 0));  // ack frees, issue still blocked
      vecs.push_back(v(0, 0, 1, 3, 0, 0,  1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 1, 2, 0, 0,  1, 0, 0, 3, 2, 3));
      vecs.push_back(v(0, 0, 0, 0, 0, 2,  1, 0, 0, 3, 2, 3));  // ack 2'b10 retires nothing
      vecs.push_back(v(0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 3, 0));
      vecs.push_back(v(0, 0, 1, 4, 0, 1,  1, 0, 0, 1, 4, 0));
      vecs.push_back(v(0, 0, 1, 6, 0, 0,  1, 0, 0, 1, 4, 0));  // out-of-order writeback
      vecs.push_back(v(0, 0, 1, 5, 0, 0,  1, 0, 0, 3, 4, 5));
      vecs.push_back(v(0, 1, 0, 0, 0, 3,  1, 1, 0, 1, 6, 0));  // issue + retire together
      vecs.push_back(v(0, 0, 1, 7, 0, 0,  1, 1, 0, 3, 6, 7));
      vecs.push_back(v(0, 0, 0, 0, 0, 1,  1, 1, 0, 1, 7, 0));
      vecs.push_back(v(0, 0, 1, 0, 0, 0,  1, 1, 0, 3, 7, 0));  // head 7, port 1 wraps to ID 0
      vecs.push_back(v(0, 0, 0, 0, 0, 3,  1, 1, 1, 0, 0, 0));
      for (int k = 2; k <= 6; k++) vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, k, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 1, 1, 0, 0,  1, 6, 0, 1, 1, 0));
      vecs.push_back(v(1, 1, 1, 2, 0, 3,  1, 0, 1, 0, 0, 0));  // flush collision
      vecs.push_back(v(0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0));

      foreach (vecs[i]) begin
         flush_i          = (vecs[i].fl != 0);
         issue_valid_i    = (vecs[i].iss != 0);
         issue_instr_i    = mk_instr(n_issued);
         n_issued++;
         wb_valid_i       = {2'b00, 2'(vecs[i].wbv)};
         wb_trans_id_i[0] = 3'(vecs[i].id0);
         wb_trans_id_i[1] = 3'(vecs[i].id1);
         wb_result_i[0]   = 64'hA000 + 64'(vecs[i].id0);
         wb_result_i[1]   = 64'hA000 + 64'(vecs[i].id1);
         commit_ack_i     = 2'(vecs[i].ack);
         step();
         chk($sformatf("row%0d ready", i), 64'(issue_ready_o), 64'(vecs[i].rdy));
         chk($sformatf("row%0d tid", i), 64'(issue_trans_id_o), 64'(vecs[i].tid));
         chk($sformatf("row%0d empty", i), 64'(empty_o), 64'(vecs[i].emp));
         chk($sformatf("row%0d cv", i), 64'(cv_now()), 64'(vecs[i].cv));
         if ((vecs[i].cv & 1) != 0) begin
            chk($sformatf("row%0d c0 id", i), 64'(commit_instr_o[0].trans_id), 64'(vecs[i].c0));
            chk($sformatf("row%0d c0 result", i), commit_instr_o[0].result,
                64'hA000 + 64'(vecs[i].c0));
            chk($sformatf("row%0d c0 exv", i), 64'(commit_instr_o[0].ex.valid), 64'd0);
         end
         if ((vecs[i].cv & 2) != 0) begin
            chk($sformatf("row%0d c1 id", i), 64'(commit_instr_o[1].trans_id), 64'(vecs[i].c1));
         end
      end
      clear_inputs();

      // Exception merge: head and tail both sit at 1 here.
      do_issue(1);
      do_issue(2);
      do_issue(3);
      wb_valid_i       = 4'b1011;
      wb_trans_id_i[0] = 3'd1;
      wb_trans_id_i[1] = 3'd2;
      wb_trans_id_i[3] = 3'd3;
      wb_result_i[0]   = 64'hA001;
      wb_result_i[1]   = 64'hA002;
      wb_result_i[3]   = 64'hB003;
      wb_ex_i[3]       = '{64'd13, 64'h0, 1'b1};
      step();
      clear_inputs();
      chk("exc cv before", 64'(cv_now()), 64'd3);
      chk("exc clean entry exv", 64'(commit_instr_o[0].ex.valid), 64'd0);
      do_ack(2'b11);
      chk("exc cv at head", 64'(cv_now()), 64'd1);
      chk("exc head id", 64'(commit_instr_o[0].trans_id), 64'd3);
      chk("exc exv", 64'(commit_instr_o[0].ex.valid), 64'd1);
      chk("exc cause", commit_instr_o[0].ex.cause, 64'd13);
      chk("exc result", commit_instr_o[0].result, 64'hB003);
      do_ack(2'b01);
      chk("exc drained", 64'(empty_o), 64'd1);

      // Mid-burst asynchronous reset with the queue full and two entries presenting.
      for (int k = 0; k < 8; k++) do_issue((4 + k) % 8);
      chk("burst full", 64'(issue_ready_o), 64'd0);
      do_wb(4, 5);
      chk("burst cv", 64'(cv_now()), 64'd3);
      #2;
      rst_i = 1'b1;
      #1;
      chk("async rst cv", 64'(cv_now()), 64'd0);
      chk("async rst ready", 64'(issue_ready_o), 64'd1);
      chk("async rst empty", 64'(empty_o), 64'd1);
      chk("async rst tid", 64'(issue_trans_id_o), 64'd0);
      step();
      rst_i = 1'b0;

      // Wrap-around: six through the queue, then four more get IDs 6, 7, 0, 1.
      for (int k = 0; k < 6; k++) do_issue(k);
      do_wb(0, 1);
      do_wb(2, 3);
      do_wb(4, 5);
      for (int k = 0; k < 3; k++) do_ack(2'b11);
      chk("wrap empty", 64'(empty_o), 64'd1);
      do_issue(6);
      do_issue(7);
      do_issue(0);
      do_issue(1);
      do_wb(6, 7);
      chk("wrap c0 id", 64'(commit_instr_o[0].trans_id), 64'd6);
      chk("wrap c1 id", 64'(commit_instr_o[1].trans_id), 64'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
